// File: rtl/serial_is_equal_pkg.sv
// Shared definitions for the bit-serial equality comparator.
//   - state encoding for the comparator FSM
//   - default operand width
package serial_is_equal_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/serial_is_equal_eq_bit_cell.sv
// Single-bit compare cell: one xor and one or.
// Ports:
//   i_a, i_b          operand bits under comparison
//   i_mismatch        mismatch accumulated over earlier bits
//   o_diff            i_a differs from i_b
//   o_mismatch_next   i_mismatch | (i_a ^ i_b)
module eq_bit_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_mismatch,
  output logic o_diff,
  output logic o_mismatch_next
);

  assign o_diff          = i_a ^ i_b;
  assign o_mismatch_next = i_mismatch | o_diff;

endmodule

// File: rtl/serial_is_equal.sv
// Bit-serial WIDTH-bit equality comparator. Operands are accepted via a
// valid/ready handshake, compared one bit per clock (LSB first) with a
// single eq_bit_cell, and the result (1 = equal) is returned via valid/ready.
//
// Optional feature: define EARLY_EXIT_EN to finish on the first differing
// bit instead of always walking all WIDTH bits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair x/y presented
//   in_ready   comparator idle and able to accept
//   x, y       operands, sampled only on accept
//   out_valid  result available
//   out_ready  consumer takes result
//   out        1 = operands equal, valid while out_valid
//
// state  | meaning
// IDLE   | waiting for an operand pair, in_ready high
// SHIFT  | comparing one bit per clock
// DONE   | holding result until out_ready
module serial_is_equal
  import serial_is_equal_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-1:0] r_ys;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mismatch;
  logic             r_out;
  logic             r_out_valid;

  logic             w_diff;
  logic             w_mismatch_next;
  logic             w_finish;

  eq_bit_cell u_cell (
    .i_a             (r_xs[0]),
    .i_b             (r_ys[0]),
    .i_mismatch      (r_mismatch),
    .o_diff          (w_diff),
    .o_mismatch_next (w_mismatch_next)
  );

`ifdef EARLY_EXIT_EN
  // A single differing bit settles the answer; equal operands still walk all bits.
  assign w_finish = (r_cnt == CNT_LAST) || w_diff;
`else
  assign w_finish = (r_cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_xs        <= '0;
      r_ys        <= '0;
      r_cnt       <= '0;
      r_mismatch  <= 1'b0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_xs       <= x;
            r_ys       <= y;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_mismatch <= w_mismatch_next;
          r_xs       <= {1'b0, r_xs[WIDTH-1:1]};
          r_ys       <= {1'b0, r_ys[WIDTH-1:1]};
          r_cnt      <= r_cnt + CNT_ONE;
          if (w_finish) begin
            r_out       <= ~w_mismatch_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule

// File: tb/tb_serial_is_equal.sv
module tb_serial_is_equal;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic         out;

  int checks;
  int errors;

  serial_is_equal #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;
    logic         exp_out;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: result is plain equality; latency is the full width unless the
  // early-exit build stops at the lowest differing bit.
  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a ^ b;
`ifdef EARLY_EXIT_EN
    for (int k = 0; k < W; k++)
      if (d[k]) return k + 1;
`endif
    return W;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input logic exp_out, input string name);
    int lat;
    @(negedge clk);
    chk({name, "_in_ready_pre"}, in_ready, 1);
    x = a; y = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, model_lat(a, b));
    chk({name, "_out"}, out, exp_out);
    chk({name, "_out_model"}, out, (a == b));
    chk({name, "_in_ready_busy"}, in_ready, 0);
    if (hold > 0) begin
      in_valid = 1'b1;
      x = '1; y = 16'h1234;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({name, "_hold_valid"}, out_valid, 1);
        chk({name, "_hold_out"}, out, exp_out);
        chk({name, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({name, "_post_valid"}, out_valid, 0);
    chk({name, "_post_in_ready"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb;
    int mode;
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;

    vecs[0] = '{16'hA5A5, 16'hA5A5, 0, 1'b1};
    vecs[1] = '{16'h8000, 16'h0000, 0, 1'b0};
    vecs[2] = '{16'h0001, 16'h0000, 0, 1'b0};
    vecs[3] = '{16'h1234, 16'h1234, 5, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFE, 0, 1'b0};

    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out", out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp_out, $sformatf("vec%0d", i));

    // Reset while shifting aborts the operation without a result.
    @(negedge clk);
    x = 16'h0F0F; y = 16'h0F0E; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out", out, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) chk("abort_no_result", out_valid, 0);
    end
    run_op(16'h0F0F, 16'h0F0F, 0, 1'b1, "after_abort");

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      rb = ra;
      else if (mode == 1) rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      else                rb = W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)), (ra == rb), $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
